// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier built from one 4x4 array multiplier.
// Four nibble passes accumulate into a 16-bit register behind valid/ready.
module mul (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);
    always_comb begin
        p = 8'd0;
        for (int i = 0; i < 4; i++) begin
            p = p + ({4'd0, {4{y[i]}} & x} << i);
        end
    end
endmodule

module mul8_seq_ctrl #(
    parameter int BYPASS_ZERO = 1,
    parameter int PERF_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            a,
    input  logic [7:0]            b,
    input  logic                  abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           prod,
    output logic                  busy,
    output logic [PERF_CNT_W-1:0] op_count
);
    typedef enum logic [2:0] {
        IDLE, P0, P1, P2, P3, DONE
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            a_q, a_d;
    logic [7:0]            b_q, b_d;
    logic [15:0]           acc_q, acc_d;
    logic [PERF_CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]  mul_x, mul_y;
    logic [7:0]  mul_p;
    logic [15:0] term;

    // Pass order: AL*BL, AL*BH, AH*BL, AH*BH
    assign mul_x = (state_q == P2 || state_q == P3) ? a_q[7:4] : a_q[3:0];
    assign mul_y = (state_q == P1 || state_q == P3) ? b_q[7:4] : b_q[3:0];

    mul u_mul (
        .x (mul_x),
        .y (mul_y),
        .p (mul_p)
    );

    always_comb begin
        term = {8'd0, mul_p};
        case (state_q)
            P1, P2:  term = {4'd0, mul_p, 4'd0};
            P3:      term = {mul_p, 8'd0};
            default: term = {8'd0, mul_p};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            acc_q   <= 16'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid && !abort) begin
                    a_d   = a;
                    b_d   = b;
                    acc_d = 16'd0;
                    if (BYPASS_ZERO != 0 && (a == 8'd0 || b == 8'd0))
                        state_d = DONE;
                    else
                        state_d = P0;
                end
            end
            P0, P1, P2, P3: begin
                if (abort) begin
                    state_d = IDLE;
                    acc_d   = 16'd0;
                end else begin
                    acc_d = acc_q + term;
                    case (state_q)
                        P0:      state_d = P1;
                        P1:      state_d = P2;
                        P2:      state_d = P3;
                        default: state_d = DONE;
                    endcase
                end
            end
            DONE: begin
                if (abort) begin
                    state_d = IDLE;
                    acc_d   = 16'd0;
                end else if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !abort && !rst;
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        prod      = acc_q;
        op_count  = cnt_q;
    end
endmodule
